// File: rtl/debounce_pkg.sv
// Shared types for the pin-input debouncer: FSM state encoding and the
// mapping from the configured idle level to the matching reset state.
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LO,
        PEND_HI,
        STABLE_HI,
        PEND_LO
    } deb_state_t;

    function automatic deb_state_t reset_state(input logic init_level);
        return init_level ? STABLE_HI : STABLE_LO;
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Plain flop chain that brings an asynchronous pin into the clk domain.
// No logic between stages so the tool can treat it as a metastability chain.
module sync_chain #(
    parameter int STAGES = 2,
    parameter bit INIT   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ff_q <= {STAGES{INIT}};
        end else begin
            ff_q <= {ff_q[STAGES-2:0], d};
        end
    end

    assign q = ff_q[STAGES-1];

endmodule

// File: rtl/signal_debouncer.sv
// Debounces an asynchronous pin: synchronize, then accept a level change only
// after STABLE_CYCLES agreeing samples. Emits edge strobes and counts glitches.
module signal_debouncer
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter bit INIT_LEVEL    = 1'b0,
    parameter int GLITCH_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    raw_in,
    input  logic                    clear_glitches,
    output logic                    clean_level,
    output logic                    rise_pulse,
    output logic                    fall_pulse,
    output logic [GLITCH_WIDTH-1:0] glitch_count
);

    localparam int            CW       = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic s;

    sync_chain #(
        .STAGES (SYNC_STAGES),
        .INIT   (INIT_LEVEL)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (raw_in),
        .q     (s)
    );

    deb_state_t        state_q;
    logic [CW-1:0]     cnt_q;
    logic              clean_q;
    logic              rise_q;
    logic              fall_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= reset_state(INIT_LEVEL);
            cnt_q   <= '0;
            clean_q <= INIT_LEVEL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            case (state_q)
                STABLE_LO: begin
                    if (s) begin
                        state_q <= PEND_HI;
                        cnt_q   <= CNT_ONE;
                    end
                end
                PEND_HI: begin
                    if (!s) begin
                        state_q <= STABLE_LO;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= STABLE_HI;
                        cnt_q   <= '0;
                        clean_q <= 1'b1;
                        rise_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                STABLE_HI: begin
                    if (!s) begin
                        state_q <= PEND_LO;
                        cnt_q   <= CNT_ONE;
                    end
                end
                PEND_LO: begin
                    if (s) begin
                        state_q <= STABLE_HI;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= STABLE_LO;
                        cnt_q   <= '0;
                        clean_q <= 1'b0;
                        fall_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= reset_state(INIT_LEVEL);
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // A glitch is a pending change abandoned because s fell back to the old level.
    logic glitch_evt;
    assign glitch_evt = ((state_q == PEND_HI) && !s) || ((state_q == PEND_LO) && s);

    logic [GLITCH_WIDTH-1:0] glitch_d, glitch_q;

    always_comb begin
        glitch_d = glitch_q;
        if (clear_glitches) begin
            glitch_d = '0;
        end else if (glitch_evt && (glitch_q != '1)) begin
            glitch_d = glitch_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            glitch_q <= '0;
        end else begin
            glitch_q <= glitch_d;
        end
    end

    assign clean_level  = clean_q;
    assign rise_pulse   = rise_q;
    assign fall_pulse   = fall_q;
    assign glitch_count = glitch_q;

endmodule

// File: tb/tb_signal_debouncer.sv
// Directed bench for signal_debouncer: default instance plus a 2-bit glitch
// counter instance sharing the same stimulus to exercise saturation.
module tb_signal_debouncer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        raw_in = 1'b0;
    logic        clear_glitches = 1'b0;
    logic        clean_level, rise_pulse, fall_pulse;
    logic [15:0] glitch_count;
    logic        clean_w2, rise_w2, fall_w2;
    logic [1:0]  glitch_w2;

    int n_chk = 0;
    int n_err = 0;
    int rise_cnt = 0;
    int fall_cnt = 0;
    int both_hi = 0;

    always #5 clk = ~clk;

    signal_debouncer dut (
        .clk            (clk),
        .reset          (reset),
        .raw_in         (raw_in),
        .clear_glitches (clear_glitches),
        .clean_level    (clean_level),
        .rise_pulse     (rise_pulse),
        .fall_pulse     (fall_pulse),
        .glitch_count   (glitch_count)
    );

    signal_debouncer #(.GLITCH_WIDTH(2)) dut_w2 (
        .clk            (clk),
        .reset          (reset),
        .raw_in         (raw_in),
        .clear_glitches (clear_glitches),
        .clean_level    (clean_w2),
        .rise_pulse     (rise_w2),
        .fall_pulse     (fall_w2),
        .glitch_count   (glitch_w2)
    );

    // Pulses are registered and last a whole cycle, so one sample per cycle counts each once.
    always @(negedge clk) begin
        if (rise_pulse) rise_cnt++;
        if (fall_pulse) fall_cnt++;
        if (rise_pulse && fall_pulse) both_hi++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic put(input logic v, input int n);
        raw_in = v;
        tick(n);
    endtask

    task automatic rst_pulse();
        reset = 1'b0;
        raw_in = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(1);
    endtask

    int r0, f0;

    initial begin
        // 1: reset holds outputs while raw_in toggles; release emits no pulse
        for (int i = 0; i < 6; i++) begin
            raw_in = i[0];
            tick(1);
        end
        chk("rst_clean", clean_level, 0);
        chk("rst_pulses", {rise_pulse, fall_pulse}, 0);
        chk("rst_glitch", glitch_count, 0);
        raw_in = 1'b0;
        reset = 1'b1;
        tick(8);
        chk("release_no_pulse", rise_cnt + fall_cnt, 0);
        chk("release_clean", clean_level, 0);

        // 2: clean step up then down, 6-edge latency, 1-cycle strobes
        raw_in = 1'b1;
        tick(5);
        chk("step_up_e5_clean", clean_level, 0);
        tick(1);
        chk("step_up_e6_clean", clean_level, 1);
        chk("step_up_e6_rise", rise_pulse, 1);
        tick(1);
        chk("step_up_e7_rise", rise_pulse, 0);
        chk("step_up_e7_clean", clean_level, 1);
        tick(3);
        raw_in = 1'b0;
        tick(5);
        chk("step_dn_e5_clean", clean_level, 1);
        tick(1);
        chk("step_dn_e6_clean", clean_level, 0);
        chk("step_dn_e6_fall", fall_pulse, 1);
        tick(1);
        chk("step_dn_e7_fall", fall_pulse, 0);
        tick(3);

        // 3: bounce shorter than the stable window is rejected twice
        r0 = rise_cnt;
        put(1'b1, 3);
        put(1'b0, 1);
        put(1'b1, 2);
        put(1'b0, 10);
        chk("bounce_clean", clean_level, 0);
        chk("bounce_no_rise", rise_cnt - r0, 0);
        chk("bounce_glitch", glitch_count, 2);

        // 4: saturation of a 2-bit counter, then clear coincident with a glitch
        rst_pulse();
        for (int g = 0; g < 5; g++) begin
            put(1'b1, 1);
            put(1'b0, 1);
        end
        tick(4);
        chk("sat_w16", glitch_count, 5);
        chk("sat_w2", glitch_w2, 3);
        put(1'b1, 1);
        put(1'b0, 2);
        clear_glitches = 1'b1;
        tick(1);
        clear_glitches = 1'b0;
        chk("clear_wins_w16", glitch_count, 0);
        chk("clear_wins_w2", glitch_w2, 0);
        tick(4);
        chk("clear_hold_w16", glitch_count, 0);

        // 5: reset mid-PEND_HI restarts the full stable run
        rst_pulse();
        put(1'b1, 4);
        #2 reset = 1'b0;
        #1;
        chk("midpend_clean", clean_level, 0);
        chk("midpend_pulses", {rise_pulse, fall_pulse}, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick(5);
        chk("restart_e5_clean", clean_level, 0);
        tick(1);
        chk("restart_e6_clean", clean_level, 1);
        chk("restart_e6_rise", rise_pulse, 1);
        chk("restart_glitch", glitch_count, 0);
        tick(2);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_hi_clean", clean_level, 0);
        chk("async_rst_hi_fall", fall_pulse, 0);
        @(posedge clk);
        #1;
        raw_in = 1'b0;
        reset = 1'b1;
        tick(3);

        // 6: ten bouncy pulses give ten clean rises and falls
        rst_pulse();
        r0 = rise_cnt;
        f0 = fall_cnt;
        for (int p = 0; p < 10; p++) begin
            put(1'b1, 1); put(1'b0, 1); put(1'b1, 1); put(1'b0, 1);
            put(1'b1, 8);
            put(1'b0, 1); put(1'b1, 1);
            put(1'b0, 9);
        end
        tick(4);
        chk("chain_rise", rise_cnt - r0, 10);
        chk("chain_fall", fall_cnt - f0, 10);
        chk("chain_clean", clean_level, 0);
        chk("chain_glitch_w16", glitch_count, 30);
        chk("chain_glitch_w2", glitch_w2, 3);
        chk("never_both_pulses", both_hi, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
